// File: rtl/cam_st_packetizer.sv
// Packs the camera RGB565 pixel stream into framed 30-bit Avalon-ST video packets.
// A framing FSM writes {sop, eop, data30} entries into a FIFO that a registered output stage drains.

module cam_st_packetizer #(
    parameter int FRAME_W    = 320,
    parameter int FRAME_H    = 240,
    parameter int FIFO_DEPTH = 512
) (
    input  logic        clk_clk,
    input  logic        reset_reset_n,
    input  logic        pix_valid,
    input  logic        pix_sof,
    input  logic [15:0] pix_data,
    output logic [29:0] st_data,
    output logic        st_valid,
    input  logic        st_ready,
    output logic        st_sop,
    output logic        st_eop,
    output logic        overflow,
    output logic        short_frame,
    output logic [15:0] frame_count
);

    localparam int NPIX = FRAME_W * FRAME_H;
    localparam int PW   = (NPIX > 1) ? $clog2(NPIX) : 1;
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam logic [PW-1:0] LAST    = PW'(NPIX - 1);
    localparam logic [AW:0]   DEPTH_C = (AW + 1)'(FIFO_DEPTH);
    localparam logic [31:0]   PAD_ENTRY = {1'b0, 1'b1, 30'd0};

    typedef enum logic [1:0] {
        WAIT_SOF = 2'd0,
        CAPTURE  = 2'd1,
        FLUSH    = 2'd2
    } state_t;

    function automatic logic [29:0] expand_rgb565(input logic [15:0] p);
        return {p[15:11], p[15:11], p[10:5], p[10:7], p[4:0], p[4:0]};
    endfunction

    state_t          state_r, state_nxt_s;
    logic [PW-1:0]   pcnt_r, pcnt_nxt_s;
    logic [31:0]     mem_r [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr_r, rd_ptr_r;
    logic [AW:0]     count_r, count_nxt_s;
    logic            full_s, empty_s;
    logic            wr_en_s, rd_en_s;
    logic [31:0]     wr_entry_s, head_s;
    logic [29:0]     pix30_s;
    logic            ovf_set_s, frame_done_s;
    logic            st_valid_r, st_sop_r, st_eop_r;
    logic [29:0]     st_data_r;
    logic            overflow_r, short_frame_r;
    logic [15:0]     frame_count_r;

    assign pix30_s = expand_rgb565(pix_data);
    assign full_s  = (count_r == DEPTH_C);
    assign empty_s = (count_r == '0);
    assign head_s  = mem_r[rd_ptr_r];
    // The output register loads whenever it is empty or being consumed this cycle.
    assign rd_en_s = !empty_s && (!st_valid_r || st_ready);

    // Framing FSM: next state, pixel counter and FIFO write decision.
    always_comb begin
        state_nxt_s  = state_r;
        pcnt_nxt_s   = pcnt_r;
        wr_en_s      = 1'b0;
        wr_entry_s   = {1'b0, 1'b0, pix30_s};
        ovf_set_s    = 1'b0;
        frame_done_s = 1'b0;
        case (state_r)
            WAIT_SOF: begin
                if (pix_valid && pix_sof) begin
                    if (full_s) begin
                        // No packet has been opened yet, so the lost sof needs no EOP.
                        ovf_set_s = 1'b1;
                    end else begin
                        wr_en_s    = 1'b1;
                        wr_entry_s = {1'b1, (LAST == '0), pix30_s};
                        if (LAST == '0) begin
                            frame_done_s = 1'b1;
                            pcnt_nxt_s   = '0;
                        end else begin
                            state_nxt_s = CAPTURE;
                            pcnt_nxt_s  = PW'(1);
                        end
                    end
                end else begin
                    state_nxt_s = WAIT_SOF;
                end
            end
            CAPTURE: begin
                if (pix_valid) begin
                    if (full_s) begin
                        ovf_set_s   = 1'b1;
                        state_nxt_s = FLUSH;
                    end else if (pix_sof) begin
                        state_nxt_s = FLUSH;
                    end else begin
                        wr_en_s    = 1'b1;
                        wr_entry_s = {1'b0, (pcnt_r == LAST), pix30_s};
                        if (pcnt_r == LAST) begin
                            frame_done_s = 1'b1;
                            state_nxt_s  = WAIT_SOF;
                            pcnt_nxt_s   = '0;
                        end else begin
                            pcnt_nxt_s = pcnt_r + PW'(1);
                        end
                    end
                end else begin
                    state_nxt_s = CAPTURE;
                end
            end
            FLUSH: begin
                if (!full_s) begin
                    wr_en_s     = 1'b1;
                    wr_entry_s  = PAD_ENTRY;
                    state_nxt_s = WAIT_SOF;
                    pcnt_nxt_s  = '0;
                end else begin
                    state_nxt_s = FLUSH;
                end
            end
            default: begin
                state_nxt_s = WAIT_SOF;
                pcnt_nxt_s  = '0;
            end
        endcase
    end

    // FIFO occupancy after this cycle's write and read.
    always_comb begin
        count_nxt_s = count_r;
        case ({wr_en_s, rd_en_s})
            2'b10:   count_nxt_s = count_r + (AW + 1)'(1);
            2'b01:   count_nxt_s = count_r - (AW + 1)'(1);
            default: count_nxt_s = count_r;
        endcase
    end

    // FSM state and pixel counter.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_r <= WAIT_SOF;
            pcnt_r  <= '0;
        end else begin
            state_r <= state_nxt_s;
            pcnt_r  <= pcnt_nxt_s;
        end
    end

    // FIFO storage; contents need no reset because the pointers define validity.
    always_ff @(posedge clk_clk) begin
        if (wr_en_s) begin
            mem_r[wr_ptr_r] <= wr_entry_s;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (wr_en_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (rd_en_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            count_r <= count_nxt_s;
        end
    end

    // Registered output stage holding one beat until the sink accepts it.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            st_valid_r <= 1'b0;
            st_sop_r   <= 1'b0;
            st_eop_r   <= 1'b0;
            st_data_r  <= 30'd0;
        end else if (rd_en_s) begin
            st_valid_r <= 1'b1;
            st_sop_r   <= head_s[31];
            st_eop_r   <= head_s[30];
            st_data_r  <= head_s[29:0];
        end else if (st_ready) begin
            st_valid_r <= 1'b0;
        end
    end

    // Status flags; short_frame is computed one cycle ahead so it coincides with the pad write.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            overflow_r    <= 1'b0;
            short_frame_r <= 1'b0;
            frame_count_r <= 16'd0;
        end else begin
            overflow_r    <= overflow_r | ovf_set_s;
            short_frame_r <= (state_nxt_s == FLUSH) && (count_nxt_s != DEPTH_C);
            if (frame_done_s) begin
                frame_count_r <= frame_count_r + 16'd1;
            end
        end
    end

    assign st_valid    = st_valid_r;
    assign st_sop      = st_sop_r;
    assign st_eop      = st_eop_r;
    assign st_data     = st_data_r;
    assign overflow    = overflow_r;
    assign short_frame = short_frame_r;
    assign frame_count = frame_count_r;

endmodule
